// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the iterative SubBytes datapath and its S-box.
//   AES_STATE_W / AES_BYTE_W : width of an AES state and of one state byte
//   AES_NUM_BYTES            : bytes per state
//   AES_BYTE_IDX_W           : bits needed to name one of the state bytes
//   AES_BIT_IDX_W            : bits needed to address a bit of the state
//   aes_state_e              : three-state FSM of the iterative block
//   byte_lsb()               : bit offset of state byte n inside the vector
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_STATE_W    = 128;
    localparam int AES_BYTE_W     = 8;
    localparam int AES_NUM_BYTES  = AES_STATE_W / AES_BYTE_W;
    localparam int AES_BYTE_IDX_W = $clog2(AES_NUM_BYTES);
    localparam int AES_BIT_IDX_W  = $clog2(AES_STATE_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    // Byte 0 sits in the top byte of the vector and byte 15 in the bottom
    // one, so the least significant bit of byte n is 8*(15-n). For a 4-bit
    // n, 15-n is simply ~n, which keeps this a pure rewiring.
    function automatic logic [AES_BIT_IDX_W-1:0] byte_lsb(
        input logic [AES_BYTE_IDX_W-1:0] n
    );
        return {~n, 3'b000};
    endfunction

endpackage

// File: rtl/sub_bytes_iter_sbox.sv
// ---------------------------------------------------------------------------
// SBox
// Combinational AES forward S-box for one byte.
//   dout     : substituted byte, forced to zero while valid_in is low
//   valid_in : lookup enable
//   addr     : byte to substitute
// ---------------------------------------------------------------------------
module SBox
    import aes_pkg::*;
(
    output logic [AES_BYTE_W-1:0] dout,
    input  logic                  valid_in,
    input  logic [AES_BYTE_W-1:0] addr
);

    // Entry 0 is the leftmost byte of the first row.
    localparam logic [0:255][7:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Gating the output keeps idle lookups from toggling downstream logic.
    assign dout = valid_in ? SBOX_TABLE[addr] : '0;

endmodule

// File: rtl/sub_bytes_iter.sv
// ---------------------------------------------------------------------------
// sub_bytes_iter
// Iterative AES SubBytes: substitutes BYTES_PER_CYCLE state bytes per clock,
// finishing one 128-bit state in N = 16/BYTES_PER_CYCLE cycles.
//   clk       : clock, all state changes on its rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : in_data carries a state to process
//   in_data   : input state, byte 0 in [127:120]
//   in_ready  : block is idle and will take a state
//   out_valid : out_data holds a finished state
//   out_data  : substituted state (same byte order), equals the work register
//   out_ready : downstream takes out_data
//   busy      : substitution in progress
// ---------------------------------------------------------------------------
module sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [AES_STATE_W-1:0] in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [AES_STATE_W-1:0] out_data,
    input  logic                   out_ready,
    output logic                   busy
);

    localparam int N     = AES_NUM_BYTES / BYTES_PER_CYCLE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    aes_state_e               state;
    logic [IDX_W-1:0]         idx;
    logic [AES_STATE_W-1:0]   work;
    logic [AES_STATE_W-1:0]   sub_work;
    logic [AES_BYTE_IDX_W-1:0] base;
    logic [AES_BYTE_IDX_W-1:0] sel       [BYTES_PER_CYCLE];
    logic [AES_BYTE_W-1:0]     sbox_addr [BYTES_PER_CYCLE];
    logic [AES_BYTE_W-1:0]     sbox_dout [BYTES_PER_CYCLE];

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == SUB);
    assign out_data  = work;

    // First byte of the chunk handled this cycle. With N == 1 idx is always
    // zero, so truncating the product never loses a set bit.
    assign base = AES_BYTE_IDX_W'(32'(idx) * BYTES_PER_CYCLE);

    // One S-box lane per byte of the chunk; each lane reads its byte straight
    // out of the work register.
    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
        assign sel[g]       = base + AES_BYTE_IDX_W'(g);
        assign sbox_addr[g] = work[byte_lsb(sel[g]) +: AES_BYTE_W];

        SBox u_sbox (
            .dout     (sbox_dout[g]),
            .valid_in (busy),
            .addr     (sbox_addr[g])
        );
    end

    // Work register with the current chunk replaced by the lane outputs;
    // only consumed while in SUB.
    always_comb begin
        sub_work = work;
        for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
            sub_work[byte_lsb(sel[g]) +: AES_BYTE_W] = sbox_dout[g];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            work  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= in_data;
                        idx   <= '0;
                        state <= SUB;
                    end
                end
                SUB: begin
                    work <= sub_work;
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// ---------------------------------------------------------------------------
// tb_sub_bytes_iter
// Self-checking bench for sub_bytes_iter at BYTES_PER_CYCLE = 4, 1 and 16.
// ---------------------------------------------------------------------------
module tb_sub_bytes_iter;

    localparam logic [127:0] VEC_IN  = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] VEC_OUT = 128'h63cab7040953d051cd60e0e7ba70e18c;
    localparam logic [127:0] ALL00   = {16{8'h00}};
    localparam logic [127:0] ALL63   = {16{8'h63}};
    localparam logic [127:0] ALLFF   = {16{8'hff}};
    localparam logic [127:0] ALL16   = {16{8'h16}};
    localparam int           LIMIT   = 100;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_data;
    logic         out_ready;
    logic         in_valid4, in_valid1, in_valid16;
    logic         in_ready4, in_ready1, in_ready16;
    logic         out_valid4, out_valid1, out_valid16;
    logic         busy4, busy1, busy16;
    logic [127:0] out_data4, out_data1, out_data16;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sub_bytes_iter #(.BYTES_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_data(in_data),
        .in_ready(in_ready4), .out_valid(out_valid4), .out_data(out_data4),
        .out_ready(out_ready), .busy(busy4)
    );

    sub_bytes_iter #(.BYTES_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
        .out_ready(out_ready), .busy(busy1)
    );

    sub_bytes_iter #(.BYTES_PER_CYCLE(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_data(in_data),
        .in_ready(in_ready16), .out_valid(out_valid16), .out_data(out_data16),
        .out_ready(out_ready), .busy(busy16)
    );

    // Reference S-box from GF(2^8) arithmetic: multiplicative inverse
    // followed by the AES affine transform.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_model(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        logic [7:0] s;
        for (int c = 1; c < 256; c++) begin
            if (gf_mul(x, 8'(c)) == 8'h01) inv = 8'(c);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [127:0] sub_bytes_model(input logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_model(x[8*i +: 8]);
        return r;
    endfunction

    // Waits, from just after an acceptance edge, for the chosen instance to
    // raise out_valid; returns the number of edges taken (LIMIT on timeout).
    task automatic wait_valid(input int which, output int cycles);
        logic v;
        cycles = 0;
        v = (which == 1) ? out_valid1 : (which == 16) ? out_valid16 : out_valid4;
        while (!v && cycles < LIMIT) begin
            @(posedge clk); #1;
            cycles++;
            v = (which == 1) ? out_valid1 : (which == 16) ? out_valid16 : out_valid4;
        end
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3;
        checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready4); end
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid4); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy4); end
        checks++; if (out_data4 !== ALL00) begin errors++; $display("FAIL reset_out_data got %h want %h", out_data4, ALL00); end
        checks++; if ({in_ready1, in_ready16} !== 2'b11) begin errors++; $display("FAIL reset_in_ready_variants got %b want 11", {in_ready1, in_ready16}); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_vector;
        int lat;
        out_ready = 1'b1;
        in_data   = VEC_IN;
        in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        checks++; if (busy4 !== 1'b1 || in_ready4 !== 1'b0) begin errors++; $display("FAIL vector_busy got busy=%b in_ready=%b want 1/0", busy4, in_ready4); end
        wait_valid(4, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL vector_latency got %0d want 4", lat); end
        checks++; if (out_data4 !== VEC_OUT) begin errors++; $display("FAIL vector_data got %h want %h", out_data4, VEC_OUT); end
        checks++; if (in_ready4 !== 1'b0) begin errors++; $display("FAIL vector_no_passthrough got in_ready=%b want 0", in_ready4); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin errors++; $display("FAIL vector_return_idle got out_valid=%b in_ready=%b want 0/1", out_valid4, in_ready4); end
    endtask

    task automatic test_boundary;
        logic [127:0] stim [2];
        logic [127:0] want [2];
        int lat;
        stim[0] = ALL00; want[0] = ALL63;
        stim[1] = ALLFF; want[1] = ALL16;
        for (int i = 0; i < 2; i++) begin
            in_data   = stim[i];
            in_valid4 = 1'b1;
            @(posedge clk); #1;
            in_valid4 = 1'b0;
            wait_valid(4, lat);
            checks++; if (out_data4 !== want[i] || lat !== 4) begin errors++; $display("FAIL boundary_%0d got %h lat %0d want %h lat 4", i, out_data4, lat, want[i]); end
            handshake();
        end
    endtask

    task automatic test_variants;
        int lat;
        in_data   = VEC_IN;
        in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL bpc1_busy got %b want 1", busy1); end
        wait_valid(1, lat);
        checks++; if (lat !== 16) begin errors++; $display("FAIL bpc1_latency got %0d want 16", lat); end
        checks++; if (out_data1 !== VEC_OUT) begin errors++; $display("FAIL bpc1_data got %h want %h", out_data1, VEC_OUT); end
        handshake();

        in_data    = ALLFF;
        in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        wait_valid(16, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL bpc16_latency got %0d want 1", lat); end
        checks++; if (out_data16 !== ALL16) begin errors++; $display("FAIL bpc16_data got %h want %h", out_data16, ALL16); end
        handshake();
    endtask

    task automatic test_backpressure;
        int lat;
        out_ready = 1'b0;
        in_data   = VEC_IN;
        in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        wait_valid(4, lat);
        // Offer a new block while the finished one is stalled.
        in_data   = ALL00;
        in_valid4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid4 !== 1'b1 || out_data4 !== VEC_OUT || in_ready4 !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold_%0d got valid=%b ready=%b data=%h want 1/0/%h", i, out_valid4, in_ready4, out_data4, VEC_OUT);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin errors++; $display("FAIL backpressure_release got in_ready=%b out_valid=%b want 1/0", in_ready4, out_valid4); end
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL backpressure_next_accept got busy=%b want 1", busy4); end
        wait_valid(4, lat);
        checks++; if (out_data4 !== ALL63 || lat !== 4) begin errors++; $display("FAIL backpressure_next_data got %h lat %0d want %h lat 4", out_data4, lat, ALL63); end
        handshake();
    endtask

    task automatic test_reset_mid;
        int lat;
        in_data   = VEC_IN;
        in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL reset_mid_busy_before got %b want 1", busy4); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid4 !== 1'b0 || busy4 !== 1'b0 || in_ready4 !== 1'b1 || out_data4 !== ALL00) begin
            errors++;
            $display("FAIL reset_mid_async got valid=%b busy=%b ready=%b data=%h want 0/0/1/0", out_valid4, busy4, in_ready4, out_data4);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        in_data   = ALL00;
        in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        wait_valid(4, lat);
        checks++; if (out_data4 !== ALL63 || lat !== 4) begin errors++; $display("FAIL reset_mid_next got %h lat %0d want %h lat 4", out_data4, lat, ALL63); end
        handshake();
    endtask

    task automatic test_busy_input;
        int c = 0;
        out_ready = 1'b0;
        in_data   = VEC_IN;
        in_valid4 = 1'b1;
        @(posedge clk); #1;
        while (!out_valid4 && c < LIMIT) begin
            in_data = {4{$urandom()}};
            @(posedge clk); #1;
            c++;
        end
        checks++; if (c !== 4) begin errors++; $display("FAIL busy_input_latency got %0d want 4", c); end
        checks++; if (out_data4 !== VEC_OUT) begin errors++; $display("FAIL busy_input_data got %h want %h", out_data4, VEC_OUT); end
        in_data = {4{$urandom()}};
        @(posedge clk); #1;
        checks++; if (out_data4 !== VEC_OUT || out_valid4 !== 1'b1) begin errors++; $display("FAIL busy_input_stable got %h valid %b want %h valid 1", out_data4, out_valid4, VEC_OUT); end
        in_valid4 = 1'b0;
        handshake();
    endtask

    task automatic test_back_to_back;
        logic [127:0] blk [8];
        logic [127:0] want;
        int c;
        int lat;
        int acc;
        int prev = 0;
        for (int i = 0; i < 8; i++) blk[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        out_ready = 1'b1;
        in_data   = blk[0];
        in_valid4 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            c = 0;
            while (!in_ready4 && c < LIMIT) begin
                @(posedge clk); #1;
                c++;
            end
            @(posedge clk); #1;
            acc = cyc;
            if (i > 0) begin
                checks++; if (acc - prev !== 6) begin errors++; $display("FAIL stream_period_%0d got %0d want 6", i, acc - prev); end
            end
            prev = acc;
            if (i < 7) in_data = blk[i+1];
            else       in_valid4 = 1'b0;
            want = sub_bytes_model(blk[i]);
            wait_valid(4, lat);
            checks++; if (out_data4 !== want || lat !== 4) begin errors++; $display("FAIL stream_data_%0d got %h lat %0d want %h lat 4", i, out_data4, lat, want); end
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        in_data    = '0;
        out_ready  = 1'b0;
        in_valid4  = 1'b0;
        in_valid1  = 1'b0;
        in_valid16 = 1'b0;
        test_reset();
        test_vector();
        test_boundary();
        test_variants();
        test_backpressure();
        test_reset_mid();
        test_busy_input();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
